// File: rtl/nn_pkg.sv
// Shared defaults and clear-FSM state encoding for the image buffer.
package nn_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LANES      = 6;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DEPTH      = 512;
  localparam int DEF_RD_PORTS   = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/nn_img_bf_mp_if.sv
// Effective write bus: the write actually applied to storage this cycle
// (user write or clear write). Read ports snoop it for write-first merging.
interface nn_img_bf_mp_if
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                        wr_en;
  logic [ADDR_WIDTH-1:0]       wr_addr;
  logic [DATA_WIDTH*LANES-1:0] wr_data;
  logic [LANES-1:0]            wr_mask;

  modport master (output wr_en, output wr_addr, output wr_data, output wr_mask);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data, input  wr_mask);
endinterface

// File: rtl/nn_img_bf_rdport.sv
// One read port: range check, write-first lane merge, registered output.
module nn_img_bf_rdport
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_rd_en,
  input  logic [ADDR_WIDTH-1:0]       i_rd_addr,
  input  logic [DATA_WIDTH*LANES-1:0] i_mem_word,
  nn_img_bf_mp_if.slave               wr,
  output logic [DATA_WIDTH*LANES-1:0] o_rd_data,
  output logic                        o_rd_valid,
  output logic                        o_rd_err
);
  localparam int TW = DATA_WIDTH * LANES;

  logic          w_in_range;
  logic          w_hit;
  logic [TW-1:0] w_merged;
  logic [TW-1:0] r_data;
  logic          r_valid;
  logic          r_err;

  assign w_in_range = 32'(i_rd_addr) < 32'(DEPTH);
  assign w_hit      = wr.wr_en && (wr.wr_addr == i_rd_addr);

  // Write-first merge: lanes being written this cycle come from the write bus.
  always_comb begin
    w_merged = i_mem_word;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (w_hit && wr.wr_mask[k])
        w_merged[k*DATA_WIDTH +: DATA_WIDTH] = wr.wr_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Output register: valid/err pulse per read, data held between reads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= i_rd_en;
      r_err   <= i_rd_en && !w_in_range;
      if (i_rd_en)
        r_data <= w_in_range ? w_merged : '0;
    end
  end

  assign o_rd_data  = r_data;
  assign o_rd_valid = r_valid;
  assign o_rd_err   = r_err;
endmodule

// File: rtl/nn_img_bf_mp.sv
// Multi-read-port lane-masked image buffer with a background clear engine.
module nn_img_bf_mp
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int RD_PORTS   = DEF_RD_PORTS
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0]                 i_wr_addr,
  input  logic [DATA_WIDTH*LANES-1:0]           i_wr_data,
  input  logic [LANES-1:0]                      i_wr_mask,
  input  logic [RD_PORTS-1:0]                   i_rd_en,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0]        i_rd_addr,
  output logic [RD_PORTS*DATA_WIDTH*LANES-1:0]  o_rd_data,
  output logic [RD_PORTS-1:0]                   o_rd_valid,
  output logic [RD_PORTS-1:0]                   o_rd_err,
  input  logic                                  i_clr,
  output logic                                  o_busy
);
  localparam int TW     = DATA_WIDTH * LANES;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [TW-1:0]         r_mem [DEPTH];
  clr_state_t            r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  r_busy;

  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [TW-1:0]         w_wr_data;
  logic [LANES-1:0]      w_wr_mask;
  logic [RD_PORTS-1:0]   w_rd_en;

  nn_img_bf_mp_if #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_bus ();

  // Select the write applied this cycle: clear word while clearing, else user write.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = i_wr_addr;
    w_wr_data = i_wr_data;
    w_wr_mask = i_wr_mask;
    if (r_state == ST_CLEAR) begin
      w_wr_en   = 1'b1;
      w_wr_addr = r_clr_cnt;
      w_wr_data = '0;
      w_wr_mask = '1;
    end else begin
      w_wr_en = i_wr_en && (32'(i_wr_addr) < 32'(DEPTH));
    end
  end

  assign u_wr_bus.wr_en   = w_wr_en;
  assign u_wr_bus.wr_addr = w_wr_addr;
  assign u_wr_bus.wr_data = w_wr_data;
  assign u_wr_bus.wr_mask = w_wr_mask;

  assign w_rd_en = (r_state == ST_CLEAR) ? '0 : i_rd_en;

  // Storage: lane-masked write, deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (w_wr_mask[k])
          r_mem[w_wr_addr[MEM_AW-1:0]][k*DATA_WIDTH +: DATA_WIDTH] <=
            w_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Clear FSM: one word zeroed per cycle, busy registered with the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_clr_cnt <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_clr) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (r_clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= '0;
            r_busy    <= 1'b0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [TW-1:0]         w_word;

    assign w_addr = i_rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_word = (32'(w_addr) < 32'(DEPTH)) ? r_mem[w_addr[MEM_AW-1:0]] : '0;

    nn_img_bf_rdport #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
    ) u_rdport (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_rd_en    (w_rd_en[p]),
      .i_rd_addr  (w_addr),
      .i_mem_word (w_word),
      .wr         (u_wr_bus.slave),
      .o_rd_data  (o_rd_data[p*TW +: TW]),
      .o_rd_valid (o_rd_valid[p]),
      .o_rd_err   (o_rd_err[p])
    );
  end
endmodule
